// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage multiply/divide unit producing {hi,lo} for MULT/MULTU/DIV/DIVU.
// Multiply finishes in one cycle. Divide is a WIDTH-step radix-2 restoring divider.
// Ports:
//   clk, rst (async, active-low), flush (abort)
//   start_i, op_div_i, signed_i, oprand1_i, oprand2_i   operation request from ID/EX
//   stall_req_o   combinational EX-hold request until the result is ready
//   valid_o       one-cycle result pulse
//   hi_o, lo_o    product high/low, or remainder/quotient
//   div_zero_o    qualifies valid_o: divisor was zero
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] oprand1_i,
  input  logic [WIDTH-1:0] oprand2_i,
  input  logic             flush,
  output logic             stall_req_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             valid_q, valid_d;

  // Operand conditioning: extension for the multiplier, magnitudes for the divider.
  logic [PW-1:0]    mul_a, mul_b, product;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    mul_a   = signed_i ? {{WIDTH{oprand1_i[WIDTH-1]}}, oprand1_i} : {{WIDTH{1'b0}}, oprand1_i};
    mul_b   = signed_i ? {{WIDTH{oprand2_i[WIDTH-1]}}, oprand2_i} : {{WIDTH{1'b0}}, oprand2_i};
    // Low 2W bits of the 2W x 2W product are correct for both signed and unsigned.
    product = PW'(mul_a * mul_b);
    a_neg   = signed_i & oprand1_i[WIDTH-1];
    b_neg   = signed_i & oprand2_i[WIDTH-1];
    a_abs   = a_neg ? WIDTH'(-oprand1_i) : oprand1_i;
    b_abs   = b_neg ? WIDTH'(-oprand2_i) : oprand2_i;
  end

  // One restoring step: shift next dividend bit into the remainder and try the subtract.
  logic [WIDTH:0]   trial, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step, quo_step;

  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]};
    diff     = trial - {1'b0, dvsr_q};
    q_bit    = ~diff[WIDTH];
    rem_step = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], q_bit};
  end

  // Next-state and result logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (!op_div_i) begin
            hi_d    = product[PW-1:WIDTH];
            lo_d    = product[WIDTH-1:0];
            dz_d    = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end else if (oprand2_i == '0) begin
            state_d = DIV_ZERO;
          end else begin
            rem_d     = '0;
            quo_d     = a_abs;
            dvsr_d    = b_abs;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = DIV_ON;
          end
        end
      end
      DIV_ZERO: begin
        hi_d    = '0;
        lo_d    = '0;
        dz_d    = 1'b1;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DIV_ON: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          hi_d    = neg_rem_q ? WIDTH'(-rem_step) : rem_step;
          lo_d    = neg_quo_q ? WIDTH'(-quo_step) : quo_step;
          dz_d    = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flush aborts without publishing anything.
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
      valid_q   <= valid_d;
    end
  end

  // Hold EX while accepting or computing; released in DONE so the instruction advances.
  assign stall_req_o = rst & (((state_q == IDLE) & start_i) |
                              (state_q == DIV_ZERO) | (state_q == DIV_ON));
  assign valid_o     = valid_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv (WIDTH=32).
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        op_div_i;
  logic        signed_i;
  logic [31:0] oprand1_i;
  logic [31:0] oprand2_i;
  logic        flush;
  logic        stall_req_o;
  logic        valid_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_zero_o;

  int total = 0;
  int bad   = 0;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_div_i   (op_div_i),
    .signed_i   (signed_i),
    .oprand1_i  (oprand1_i),
    .oprand2_i  (oprand2_i),
    .flush      (flush),
    .stall_req_o(stall_req_o),
    .valid_o    (valid_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation at a negedge, hold start_i while stalled (scrambling operands),
  // and wait (bounded) for valid_o. lat = cycles from issue to valid_o, -1 on timeout.
  task automatic run_op(input logic dv, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output int nstall);
    lat    = -1;
    nstall = 0;
    @(negedge clk);
    start_i = 1'b1; op_div_i = dv; signed_i = sg; oprand1_i = a; oprand2_i = b;
    #1 if (stall_req_o) nstall++;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (valid_o) begin
        lat = c;
        break;
      end
      if (stall_req_o) nstall++;
      oprand1_i = $urandom;
      oprand2_i = $urandom;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b1; op_div_i = 1'b0; signed_i = 1'b0;
    oprand1_i = 32'd3; oprand2_i = 32'd4; flush = 1'b1;
    #12;
    total++;
    if ({valid_o, hi_o, lo_o, div_zero_o, stall_req_o} !== 67'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b hi=%h lo=%h dz=%b st=%b, want all 0",
               valid_o, hi_o, lo_o, div_zero_o, stall_req_o);
    end
    start_i = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mul_unsigned();
    int lat, ns;
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ns);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL mulu_latency: got %0d want 1", lat); end
    total++;
    if ({hi_o, lo_o} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL mulu_result: got %h_%h want fffffffe_00000001", hi_o, lo_o);
    end
    total++;
    if (stall_req_o !== 1'b0) begin bad++; $display("FAIL mulu_done_stall: got %b want 0", stall_req_o); end
  endtask

  task automatic test_mul_signed();
    int lat, ns;
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, lat, ns);
    total++;
    if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      bad++; $display("FAIL muls_neg3x5: got %h_%h want ffffffff_fffffff1", hi_o, lo_o);
    end
    total++;
    if (ns !== 1) begin bad++; $display("FAIL muls_stall_cycles: got %0d want 1", ns); end
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, lat, ns);
    total++;
    if ({hi_o, lo_o} !== 64'h4000_0000_0000_0000 || lat !== 1) begin
      bad++; $display("FAIL muls_minxmin: got %h_%h lat=%0d want 40000000_00000000 lat=1", hi_o, lo_o, lat);
    end
  endtask

  task automatic test_div_signed();
    int lat, ns;
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, ns);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL divs_latency: got %0d want 33", lat); end
    total++;
    if (ns !== 33) begin bad++; $display("FAIL divs_stall_cycles: got %0d want 33", ns); end
    total++;
    if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF || div_zero_o !== 1'b0) begin
      bad++; $display("FAIL divs_neg7by2: got lo=%h hi=%h dz=%b want fffffffd ffffffff 0", lo_o, hi_o, div_zero_o);
    end
    total++;
    if (stall_req_o !== 1'b0) begin bad++; $display("FAIL divs_done_stall: got %b want 0", stall_req_o); end
    run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, ns);
    total++;
    if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'd1) begin
      bad++; $display("FAIL divs_7bym2: got lo=%h hi=%h want fffffffd 00000001", lo_o, hi_o);
    end
  endtask

  task automatic test_div_zero();
    int lat, ns;
    run_op(1'b1, 1'b0, 32'd100, 32'd0, lat, ns);
    total++;
    if (lat !== 2 || ns !== 2) begin
      bad++; $display("FAIL divz_timing: got lat=%0d stalls=%0d want 2 2", lat, ns);
    end
    total++;
    if (div_zero_o !== 1'b1 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      bad++; $display("FAIL divz_result: got dz=%b hi=%h lo=%h want 1 0 0", div_zero_o, hi_o, lo_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ns;
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, ns);
    total++;
    if (lo_o !== 32'h8000_0000 || hi_o !== 32'd0 || div_zero_o !== 1'b0 || lat !== 33) begin
      bad++; $display("FAIL divs_overflow: got lo=%h hi=%h dz=%b lat=%0d want 80000000 0 0 33",
                      lo_o, hi_o, div_zero_o, lat);
    end
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, lat, ns);
    total++;
    if (lo_o !== 32'h0FFF_FFFF || hi_o !== 32'hF || lat !== 33) begin
      bad++; $display("FAIL divu_ffffffff_by16: got lo=%h hi=%h lat=%0d want 0fffffff f 33", lo_o, hi_o, lat);
    end
  endtask

  task automatic test_flush();
    int pulses;
    @(negedge clk);
    start_i = 1'b1; op_div_i = 1'b1; signed_i = 1'b1; oprand1_i = 32'd1000; oprand2_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    total++;
    if (stall_req_o !== 1'b1) begin bad++; $display("FAIL flush_pre_stall: got %b want 1", stall_req_o); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (stall_req_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL flush_idle: got st=%b v=%b want 0 0", stall_req_o, valid_o);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    total++;
    if (pulses !== 0 || lo_o !== 32'h0FFF_FFFF || hi_o !== 32'hF) begin
      bad++; $display("FAIL flush_no_result: got pulses=%0d lo=%h hi=%h want 0 0fffffff f", pulses, lo_o, hi_o);
    end
    // Flush beats a simultaneous start.
    start_i = 1'b1; op_div_i = 1'b0; signed_i = 1'b0; oprand1_i = 32'd2; oprand2_i = 32'd3; flush = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush = 1'b0;
    total++;
    if (valid_o !== 1'b0 || lo_o !== 32'h0FFF_FFFF) begin
      bad++; $display("FAIL flush_over_start: got v=%b lo=%h want 0 0fffffff", valid_o, lo_o);
    end
  endtask

  task automatic test_async_reset();
    int lat, ns;
    @(negedge clk);
    start_i = 1'b1; op_div_i = 1'b1; signed_i = 1'b0; oprand1_i = 32'd555; oprand2_i = 32'd7;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({valid_o, hi_o, lo_o, div_zero_o, stall_req_o} !== 67'd0) begin
      bad++; $display("FAIL async_reset: got v=%b hi=%h lo=%h dz=%b st=%b want all 0",
                      valid_o, hi_o, lo_o, div_zero_o, stall_req_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 1'b0, 32'd7, 32'd6, lat, ns);
    total++;
    if (lo_o !== 32'd42 || hi_o !== 32'd0 || lat !== 1) begin
      bad++; $display("FAIL post_reset_mul: got lo=%h hi=%h lat=%0d want 2a 0 1", lo_o, hi_o, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul_unsigned();
    test_mul_signed();
    test_div_signed();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
